// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared definitions for the WS2812 chain transmitter.
//   - state_t   : frame-level FSM states.
//   - *_27M     : default bit and latch timings, in clk cycles at 27 MHz.
//   - cnt_width : width of a cycle counter that must reach the longest of
//                 the latch gap and the two bit periods.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int T0H_27M = 9;
  localparam int T0L_27M = 22;
  localparam int T1H_27M = 19;
  localparam int T1L_27M = 16;
  localparam int RES_27M = 1350;

  function automatic int cnt_width(input int res, input int t0, input int t1);
    int m;
    m = res;
    if (t0 > m) m = t0;
    if (t1 > m) m = t1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: serialises one BPP-bit word MSB first with WS2812 timing.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture data into the shift register, restart at bit BPP-1
//   data       : word to send
//   run        : parent is in its sending state; counters advance
//   dout       : registered serial output (one cycle behind the counter)
//   word_last  : combinational, high on the last cycle of bit 0
module ws2812_bit_tx import ws2812_pkg::*; #(
  parameter int BPP = 24,
  parameter int T0H = T0H_27M,
  parameter int T0L = T0L_27M,
  parameter int T1H = T1H_27M,
  parameter int T1L = T1L_27M,
  parameter int CW  = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [BPP-1:0] data,
  input  logic           run,
  output logic           dout,
  output logic           word_last
);

  localparam int BW = $clog2(BPP);
  localparam logic [CW-1:0] H0 = CW'(T0H);
  localparam logic [CW-1:0] H1 = CW'(T1H);
  localparam logic [CW-1:0] L0 = CW'(T0H + T0L - 1);
  localparam logic [CW-1:0] L1 = CW'(T1H + T1L - 1);
  localparam logic [BW-1:0] TOP_BIT = BW'(BPP - 1);

  logic [BPP-1:0] shreg;
  logic [CW-1:0]  cnt;
  logic [BW-1:0]  bit_idx;
  logic [CW-1:0]  high_len;
  logic [CW-1:0]  last_cnt;
  logic           bit_end;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    high_len = H0;
    last_cnt = L0;
    if (shreg[BPP-1]) begin
      high_len = H1;
      last_cnt = L1;
    end
  end

  assign bit_end   = run && (cnt == last_cnt);
  assign word_last = bit_end && (bit_idx == '0);

  always_ff @(posedge clk) begin
    // NOTE: the shift register is a handful of flops, not a memory, so it is reset along with the counters.
    if (!rst_n) begin
      shreg   <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      dout    <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      dout <= run && (cnt < high_len);
      if (load) begin
        shreg   <= data;
        cnt     <= '0;
        bit_idx <= TOP_BIT;
      end else if (bit_end) begin
        cnt     <= '0;
        shreg   <= {shreg[BPP-2:0], 1'b0};
        bit_idx <= (bit_idx == '0) ? TOP_BIT : bit_idx - BW'(1);
      end else if (run) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ws2812_chain_tx.sv
// ws2812_chain_tx: drives a chain of NUM_LEDS WS2812 pixels from a
// valid/ready pixel stream, with a one-pixel shadow buffer so the wire
// timing never stalls between pixels. Each frame ends with a RES-cycle
// latch gap.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   start       : frame request, sampled only in IDLE
//   pix_data    : pixel word, GRB[W], MSB first on the wire
//   pix_valid   : pix_data valid
//   pix_ready   : pixel accepted this cycle when pix_valid is also high
//   busy        : frame in progress, latch gap included
//   frame_done  : one-cycle pulse at the end of the latch gap
//   underrun    : one-cycle pulse when a pixel slot found the shadow empty
//   dout        : registered serial line to the first LED
module ws2812_chain_tx import ws2812_pkg::*; #(
  parameter int NUM_LEDS     = 8,
  parameter int BPP          = 24,
  parameter int T0H          = T0H_27M,
  parameter int T0L          = T0L_27M,
  parameter int T1H          = T1H_27M,
  parameter int T1L          = T1L_27M,
  parameter int RES          = RES_27M,
  parameter int AUTO_REFRESH = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [BPP-1:0] pix_data,
  input  logic           pix_valid,
  output logic           pix_ready,
  output logic           busy,
  output logic           frame_done,
  output logic           underrun,
  output logic           dout
);

  localparam int CW = cnt_width(RES, T0H + T0L, T1H + T1L);
  localparam int FW = $clog2(NUM_LEDS + 1);
  localparam logic [FW-1:0] N_PIX    = FW'(NUM_LEDS);
  localparam logic [FW-1:0] N_LAST   = FW'(NUM_LEDS - 1);
  localparam logic [CW-1:0] RES_LAST = CW'(RES - 1);

  state_t         state, state_nxt;
  logic [CW-1:0]  lcnt;
  logic [BPP-1:0] shadow;
  logic           shadow_full;
  logic [FW-1:0]  fetched;
  logic [FW-1:0]  sent;
  logic [FW:0]    fetch_sum;
  logic [FW-1:0]  fetched_nxt;
  logic           word_last;
  logic           accept;
  logic           more;
  logic           load;
  logic           load_next;
  logic           underrun_now;
  logic           frame_end_now;
  logic [BPP-1:0] load_data;

  assign busy      = (state != IDLE);
  assign pix_ready = busy && !shadow_full && (fetched < N_PIX);
  assign accept    = pix_valid && pix_ready;
  assign more      = (sent < N_LAST);
  // An empty shadow at a pixel boundary sends a dark pixel in that slot.
  assign load_data = shadow_full ? shadow : '0;

  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    load_next     = 1'b0;
    underrun_now  = 1'b0;
    frame_end_now = 1'b0;
    case (state)
      IDLE:  if (start || (AUTO_REFRESH != 0)) state_nxt = FETCH;
      FETCH: if (shadow_full) begin
               load      = 1'b1;
               state_nxt = SEND;
             end
      SEND:  if (word_last) begin
               if (more) begin
                 load         = 1'b1;
                 load_next    = 1'b1;
                 underrun_now = !shadow_full;
               end else begin
                 state_nxt = LATCH;
               end
             end
      LATCH: if (lcnt == RES_LAST) begin
               frame_end_now = 1'b1;
               state_nxt     = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // A dark (underrun) slot counts as fetched, so a late pixel fills the next
  // slot and a frame never consumes more than NUM_LEDS pixels. Saturate in
  // case a handshake lands on the same cycle as the final underrun slot.
  always_comb begin
    fetch_sum   = {1'b0, fetched} + (FW+1)'(accept) + (FW+1)'(underrun_now);
    fetched_nxt = fetch_sum[FW-1:0];
    if (fetch_sum > {1'b0, N_PIX}) fetched_nxt = N_PIX;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lcnt        <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      fetched     <= '0;
      sent        <= '0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= frame_end_now;
      underrun   <= underrun_now;
      lcnt       <= (state == LATCH && !frame_end_now) ? lcnt + CW'(1) : '0;
      if (state == IDLE) begin
        shadow_full <= 1'b0;
        fetched     <= '0;
        sent        <= '0;
      end else begin
        // accept needs an empty shadow, so it never collides with a real consume.
        if (accept) begin
          shadow      <= pix_data;
          shadow_full <= 1'b1;
        end else if (load) begin
          shadow_full <= 1'b0;
        end
        fetched <= fetched_nxt;
        if (load_next) sent <= sent + FW'(1);
      end
    end
  end

  ws2812_bit_tx #(
    .BPP (BPP),
    .T0H (T0H),
    .T0L (T0L),
    .T1H (T1H),
    .T1L (T1L),
    .CW  (CW)
  ) u_bit_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (load_data),
    .run       (state == SEND),
    .dout      (dout),
    .word_last (word_last)
  );

endmodule

// File: tb/tb_ws2812_chain_tx.sv
// tb_ws2812_chain_tx: self-checking bench for ws2812_chain_tx.
// Instance A: 3 pixels, 24 bpp, start-triggered; a scoreboard of expected
// per-bit (high, low) widths is filled from the pixel values and a monitor
// decodes dout pulses and compares. Instance B: 1 pixel, 32 bpp, all ones,
// auto-refresh; checks pulse widths, frame length and the IDLE gap.
module tb_ws2812_chain_tx;

  localparam int T0H = 9;
  localparam int T0L = 22;
  localparam int T1H = 19;
  localparam int T1L = 16;
  localparam int RES = 1350;
  // Busy spans: one cycle to accept into the shadow, one to move it into
  // the shift register, every bit period, then the latch gap.
  localparam int B_FRAME = 32 * (T1H + T1L) + RES + 2;

  localparam int MODE_NORMAL   = 0;
  localparam int MODE_UNDERRUN = 1;
  localparam int MODE_OVERRUN  = 2;

  typedef struct {
    int hi;
    int lo;
  } bit_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a;
  logic [23:0] pix_data_a;
  logic        pix_valid_a;
  logic        pix_ready_a, busy_a, frame_done_a, underrun_a, dout_a;

  logic        start_b = 1'b0;
  logic [31:0] pix_data_b = 32'hFFFF_FFFF;
  logic        pix_valid_b = 1'b1;
  logic        pix_ready_b, busy_b, frame_done_b, underrun_b, dout_b;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_cnt  = 0;
  int ur_cnt  = 0;
  int bit_seen = 0;

  bit_exp_t exp_q[$];

  always #5 clk = ~clk;

  ws2812_chain_tx #(
    .NUM_LEDS(3), .BPP(24), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L),
    .RES(RES), .AUTO_REFRESH(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .pix_data(pix_data_a),
    .pix_valid(pix_valid_a), .pix_ready(pix_ready_a), .busy(busy_a),
    .frame_done(frame_done_a), .underrun(underrun_a), .dout(dout_a)
  );

  ws2812_chain_tx #(
    .NUM_LEDS(1), .BPP(32), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L),
    .RES(RES), .AUTO_REFRESH(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .pix_data(pix_data_b),
    .pix_valid(pix_valid_b), .pix_ready(pix_ready_b), .busy(busy_b),
    .frame_done(frame_done_b), .underrun(underrun_b), .dout(dout_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each pixel slot becomes 24 bits, MSB first; a bit's
  // wire shape is fixed by its value; the frame's last low run also holds
  // the latch gap, which ends on the frame_done cycle.
  task automatic push_frame(input logic [23:0] s0, input logic [23:0] s1, input logic [23:0] s2);
    logic [23:0] slots [3];
    bit_exp_t e;
    slots[0] = s0;
    slots[1] = s1;
    slots[2] = s2;
    for (int k = 0; k < 3; k++) begin
      for (int b = 23; b >= 0; b--) begin
        e.hi = slots[k][b] ? T1H : T0H;
        e.lo = slots[k][b] ? T1L : T0L;
        if (k == 2 && b == 0) e.lo += RES;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic compare_bit(input int hi, input int lo);
    bit_exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected bit on dout", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("bit %0d high width", bit_seen), hi, e.hi);
      check($sformatf("bit %0d low width", bit_seen), lo, e.lo);
    end
    bit_seen++;
  endtask

  // Monitor A: decode dout into (high, low) runs.
  int  a_hi = 0, a_lo = 0;
  bit  a_prev = 1'b0, a_pend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      a_pend = 1'b0;
      a_prev = 1'b0;
      a_hi   = 0;
      a_lo   = 0;
    end else begin
      if (dout_a) begin
        if (!a_prev) begin
          if (a_pend) compare_bit(a_hi, a_lo);
          a_pend = 1'b1;
          a_hi   = 1;
          a_lo   = 0;
        end else begin
          a_hi++;
        end
      end else begin
        a_lo++;
      end
      a_prev = dout_a;
      if (frame_done_a) begin
        if (a_pend) compare_bit(a_hi, a_lo);
        else check("frame_done with no bits sent", 1, 0);
        a_pend = 1'b0;
        a_lo   = 0;
      end
    end
  end

  always @(negedge clk) if (rst_n && underrun_a) ur_cnt++;

  // Monitor B: auto-refresh, all-ones 32-bit pixel.
  int b_cyc = 0, b_start = 0, b_done_cyc = 0, b_hi = 0, b_pulses = 0;
  bit b_valid = 1'b0, b_have_done = 1'b0, b_prev_busy = 1'b0, b_prev_d = 1'b0;
  always @(negedge clk) begin
    b_cyc++;
    if (!rst_n) begin
      b_valid     = 1'b0;
      b_have_done = 1'b0;
      b_prev_busy = 1'b0;
      b_prev_d    = 1'b0;
      b_hi        = 0;
    end else begin
      if (busy_b && !b_prev_busy) begin
        if (b_have_done) check("B idle cycles between frames", b_cyc - b_done_cyc, 1);
        b_start  = b_cyc;
        b_pulses = 0;
        b_valid  = 1'b1;
      end
      if (dout_b) begin
        b_hi = b_prev_d ? b_hi + 1 : 1;
      end else if (b_prev_d && b_valid) begin
        check("B high pulse width", b_hi, T1H);
        b_pulses++;
      end
      if (frame_done_b && b_valid) begin
        check("B pulses per frame", b_pulses, 32);
        check("B busy length", b_cyc - b_start, B_FRAME);
        check("B busy low at frame_done", busy_b, 0);
        b_done_cyc  = b_cyc;
        b_have_done = 1'b1;
        b_valid     = 1'b0;
      end
      b_prev_busy = busy_b;
      b_prev_d    = dout_b;
    end
  end

  task automatic offer(input logic [23:0] d);
    bit got = 1'b0;
    pix_data_a  = d;
    pix_valid_a = 1'b1;
    for (int n = 0; n < 5000 && !got; n++) begin
      if (pix_ready_a) begin
        got = 1'b1;
        hs_cnt++;
      end
      @(negedge clk);
    end
    check("pixel accepted within bound", got, 1);
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int n = 0; n < 20000 && !got; n++) begin
      if (pix_valid_a && pix_ready_a) hs_cnt++;
      if (frame_done_a) got = 1'b1;
      else @(negedge clk);
    end
    check("frame_done within bound", got, 1);
  endtask

  task automatic run_frame(input int mode, input logic [23:0] p0, input logic [23:0] p1,
                           input logic [23:0] p2, input logic [23:0] p3, input logic [23:0] p4);
    int exp_hs;
    int exp_ur;
    hs_cnt = 0;
    ur_cnt = 0;
    if (mode == MODE_UNDERRUN) begin
      push_frame(p0, 24'h0, p1);
      exp_hs = 2;
      exp_ur = 1;
    end else begin
      push_frame(p0, p1, p2);
      exp_hs = 3;
      exp_ur = 0;
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    offer(p0);
    if (mode == MODE_UNDERRUN) begin
      // Pixel 0 ends no later than 2 + 24*35 cycles after start; pixel 1
      // ends no earlier than 2 + 48*31. Offering in between forces exactly
      // one dark slot and lands the late pixel in slot 2.
      pix_valid_a = 1'b0;
      repeat (900) @(negedge clk);
      offer(p1);
      pix_valid_a = 1'b0;
    end else begin
      offer(p1);
      offer(p2);
      if (mode == MODE_OVERRUN) pix_data_a = p3;
      else pix_valid_a = 1'b0;
    end
    wait_done();
    if (mode == MODE_OVERRUN) begin
      pix_data_a = p4;
      repeat (5) begin
        @(negedge clk);
        if (pix_valid_a && pix_ready_a) hs_cnt++;
      end
      pix_valid_a = 1'b0;
    end
    @(negedge clk);
    check($sformatf("handshakes mode %0d", mode), hs_cnt, exp_hs);
    check($sformatf("underrun pulses mode %0d", mode), ur_cnt, exp_ur);
    check("scoreboard drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [23:0] rnd24();
    return 24'($urandom());
  endfunction

  initial begin
    bit seen_high;
    rst_n       = 1'b0;
    start_a     = 1'b0;
    pix_valid_a = 1'b0;
    pix_data_a  = '0;
    repeat (3) @(negedge clk);
    check("reset outputs A", {dout_a, busy_a, pix_ready_a, frame_done_a, underrun_a}, 0);
    check("reset outputs B", {dout_b, busy_b, pix_ready_b, frame_done_b, underrun_b}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(MODE_NORMAL, 24'h800001, 24'h000000, rnd24(), 24'h0, 24'h0);
    run_frame(MODE_NORMAL, rnd24(), rnd24(), rnd24(), 24'h0, 24'h0);
    run_frame(MODE_NORMAL, 24'hFFFFFF, rnd24(), 24'h000001, 24'h0, 24'h0);
    run_frame(MODE_UNDERRUN, rnd24(), rnd24(), 24'h0, 24'h0, 24'h0);
    run_frame(MODE_OVERRUN, rnd24(), rnd24(), rnd24(), rnd24(), rnd24());

    // Reset during a high phase, then a full frame must start from pixel 0.
    push_frame(24'hFFFFFF, 24'h0, 24'h0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    offer(24'hFFFFFF);
    pix_valid_a = 1'b0;
    seen_high = 1'b0;
    for (int n = 0; n < 3000 && !seen_high; n++) begin
      if (dout_a) seen_high = 1'b1;
      else @(negedge clk);
    end
    check("dout high before mid-bit reset", seen_high, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid-bit reset dout", dout_a, 0);
    check("mid-bit reset busy", busy_a, 0);
    check("mid-bit reset other outputs", {pix_ready_a, frame_done_a, underrun_a}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(MODE_NORMAL, rnd24(), 24'h555555, rnd24(), 24'h0, 24'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
